// File: rtl/spi_frame_sequencer_pkg.sv
// Shared types and constants for the SPI frame sequencer.
package spi_seq_pkg;

    localparam int         SEQ_ADDR_W = 16;
    localparam int         SEQ_DEPTH  = 16384;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_START  = 8'h02;
    localparam int         HDR_LEN    = 3;

    typedef enum logic [3:0] {
        IDLE,
        LEN_H,
        LEN_L,
        PAYLOAD,
        CHK,
        KICK,
        WAIT,
        DONE,
        ERR
    } seq_state_t;

    // States that belong to an incomplete frame and are cancelled when chip-select drops.
    function automatic logic is_abortable(seq_state_t s);
        return (s == LEN_H) || (s == LEN_L) || (s == PAYLOAD) || (s == CHK);
    endfunction

    function automatic logic is_busy(seq_state_t s);
        return (s != IDLE) && (s != ERR);
    endfunction

endpackage

// File: rtl/spi_frame_sequencer_if.sv
// Byte-stream, buffer-write and dither-core signals of the frame sequencer.
interface spi_frame_sequencer_if
    import spi_seq_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W
) ();

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              cs_active;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              acc_start;
    logic              acc_busy;
    logic              acc_done;
    logic              seq_busy;
    logic              err_flag;
    logic [7:0]        frames_ok;

    modport master (
        input  byte_valid, byte_data, cs_active, acc_busy, acc_done,
        output mem_we, mem_addr, mem_wdata, acc_start, seq_busy, err_flag, frames_ok
    );

    modport slave (
        output byte_valid, byte_data, cs_active, acc_busy, acc_done,
        input  mem_we, mem_addr, mem_wdata, acc_start, seq_busy, err_flag, frames_ok
    );

endinterface

// File: rtl/spi_frame_sequencer.sv
// Parses SPI command frames into buffer writes and dither-core launches.
// Optional trailing payload checksum: SPI_FRAME_SEQ_CHECKSUM_EN.
// state | meaning: IDLE wait opcode | LEN_H/LEN_L length bytes | PAYLOAD buffer writes
//       | CHK checksum byte | KICK start pulse | WAIT core running | DONE count frame | ERR flag error
module spi_frame_sequencer
    import spi_seq_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W,
    parameter int DEPTH  = SEQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_frame_sequencer_if.master bus
);

    seq_state_t        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_start_q, is_start_d;
    logic              err_q, err_d;
    logic [7:0]        frames_q, frames_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              acc_start_q;
    logic              seq_busy_q;
    logic              cs_prev_q;
    logic [15:0]       len_new;
    logic              cs_fall;
    logic              last_byte;
`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    assign len_new   = {len_q[15:8], bus.byte_data};
    assign cs_fall   = cs_prev_q & ~bus.cs_active;
    assign last_byte = (addr_q == ADDR_W'(len_q - 16'd1));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        is_start_d  = is_start_q;
        err_d       = err_q;
        frames_d    = frames_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.byte_valid) begin
                    if ((bus.byte_data == CMD_WRITE) || (bus.byte_data == CMD_START)) begin
                        state_d    = LEN_H;
                        is_start_d = (bus.byte_data == CMD_START);
                        err_d      = 1'b0;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            LEN_H: begin
                if (bus.byte_valid) begin
                    len_d   = {bus.byte_data, len_q[7:0]};
                    state_d = LEN_L;
                end
            end
            LEN_L: begin
                if (bus.byte_valid) begin
                    len_d  = len_new;
                    addr_d = '0;
`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
                    sum_d  = 8'h00;
`endif
                    if (is_start_q) begin
                        state_d = (len_new != 16'd0) ? ERR : KICK;
                    end else if (len_new == 16'd0) begin
`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else if (int'(len_new) > DEPTH) begin
                        state_d = ERR;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.byte_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = bus.byte_data;
                    addr_d      = addr_q + ADDR_W'(1);
`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
                    sum_d       = sum_q + bus.byte_data;
                    if (last_byte) state_d = CHK;
`else
                    if (last_byte) state_d = DONE;
`endif
                end
            end
`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
            CHK: begin
                if (bus.byte_valid) begin
                    state_d = (bus.byte_data == sum_q) ? DONE : ERR;
                end
            end
`endif
            KICK: begin
                state_d = WAIT;
                if (bus.byte_valid) err_d = 1'b1;
            end
            WAIT: begin
                if (bus.acc_done) state_d = DONE;
                if (bus.byte_valid) err_d = 1'b1;
            end
            DONE: begin
                frames_d = frames_q + 8'd1;
                state_d  = IDLE;
            end
            ERR: begin
                state_d = IDLE;
                if (bus.byte_valid) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // The byte of this cycle is already accounted for; a frame it completes is not aborted.
        if (cs_fall && is_abortable(state_q) && is_abortable(state_d)) begin
            state_d = ERR;
        end
        if (state_d == ERR) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            is_start_q  <= 1'b0;
            err_q       <= 1'b0;
            frames_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            acc_start_q <= 1'b0;
            seq_busy_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            is_start_q  <= is_start_d;
            err_q       <= err_d;
            frames_q    <= frames_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            acc_start_q <= (state_d == KICK);
            seq_busy_q  <= is_busy(state_d) | bus.acc_busy;
            cs_prev_q   <= bus.cs_active;
`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.acc_start = acc_start_q;
    assign bus.seq_busy  = seq_busy_q;
    assign bus.err_flag  = err_q;
    assign bus.frames_ok = frames_q;

endmodule
